// File: rtl/mult_hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO multiplier control stage.
package mult_hilo_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_MTHI = 2'b01,
        OP_MTLO = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DROP = 2'b10
    } state_e;

    localparam int unsigned MAX_CYCLES_DEF = 40;
    localparam int unsigned CNT_W_DEF      = 6;

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// Execute-stage request bus plus multiplier begin/end bus and HI/LO status.
interface mult_hilo_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        cancel;
    logic        mult_begin;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic [63:0] product;
    logic        mult_end;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        err;

    modport master (
        output req_valid, req_op, req_src1, req_src2, cancel, product, mult_end,
        input  req_ready, mult_begin, mult_op1, mult_op2, hi, lo, busy, err
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, cancel, product, mult_end,
        output req_ready, mult_begin, mult_op1, mult_op2, hi, lo, busy, err
    );

endinterface

// File: rtl/mult_hilo_ctrl.sv
// Drives the iterative multiplier, owns architectural HI/LO, and guards each
// multiply with a cancel path and a cycle watchdog.
module mult_hilo_ctrl
    import mult_hilo_ctrl_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF  // 2**CNT_W must exceed MAX_CYCLES
) (
    input  logic             clk,
    input  logic             resetn,
    mult_hilo_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_CYCLES);

    state_e           r_state, w_state_nxt;
    logic [31:0]      r_hi, w_hi_nxt;
    logic [31:0]      r_lo, w_lo_nxt;
    logic [31:0]      r_op1, w_op1_nxt;
    logic [31:0]      r_op2, w_op2_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_err, w_err_nxt;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_accept  = bus.req_valid && (r_state == S_IDLE);
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_op1_nxt   = r_op1;
        w_op2_nxt   = r_op2;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    unique case (bus.req_op)
                        OP_MULT: begin
                            w_op1_nxt   = bus.req_src1;
                            w_op2_nxt   = bus.req_src2;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_RUN;
                        end
                        OP_MTHI: w_hi_nxt = bus.req_src1;
                        OP_MTLO: w_lo_nxt = bus.req_src1;
                        OP_RSVD: ;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                w_cnt_nxt = w_cnt_inc;
                // Cancel beats a same-cycle end; a real end beats the watchdog.
                if (bus.cancel) begin
                    w_state_nxt = S_DROP;
                end else if (bus.mult_end) begin
                    {w_hi_nxt, w_lo_nxt} = bus.product;
                    w_state_nxt          = S_DROP;
                end else if (w_cnt_inc == CntMax) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_op1   <= w_op1_nxt;
            r_op2   <= w_op2_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Begin is decoded from the state register so reset drops it asynchronously.
    assign bus.mult_begin = (r_state == S_RUN);
    assign bus.mult_op1   = r_op1;
    assign bus.mult_op2   = r_op2;
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.hi         = r_hi;
    assign bus.lo         = r_lo;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl: stub multiplier, transaction-level model checked
// every cycle, plus directed vectors with literal expected results.
module tb_mult_hilo_ctrl;

    localparam int unsigned MAXC = 40;
    localparam int unsigned LAT  = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mult_hilo_ctrl_if ifc ();

    mult_hilo_ctrl #(
        .MAX_CYCLES(MAXC),
        .CNT_W     (6)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (ifc.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Low 64 bits of sign-extended operands equal the signed 32x32 product.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    // Stub multiplier: end pulse LAT cycles after begin, or never when hang=1.
    bit          hang = 1'b0;
    int unsigned s_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_cnt        <= 0;
            ifc.mult_end <= 1'b0;
            ifc.product  <= '0;
        end else begin
            ifc.mult_end <= 1'b0;
            if (ifc.mult_begin && !hang) begin
                if (s_cnt == LAT - 1) begin
                    ifc.mult_end <= 1'b1;
                    ifc.product  <= mul64(ifc.mult_op1, ifc.mult_op2);
                end
                s_cnt <= s_cnt + 1;
            end else begin
                s_cnt <= 0;
            end
        end
    end

    // Model: phase 0 idle, 1 multiply in flight, 2 one-cycle drop.
    int          m_ph;
    int          m_run;
    logic [31:0] m_hi, m_lo, m_op1, m_op2;
    logic        m_err;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_ph  <= 0;
            m_run <= 0;
            m_hi  <= '0;
            m_lo  <= '0;
            m_op1 <= '0;
            m_op2 <= '0;
            m_err <= 1'b0;
        end else begin
            case (m_ph)
                0: if (ifc.req_valid) begin
                    if (ifc.req_op == 2'b00) begin
                        m_ph  <= 1;
                        m_run <= 0;
                        m_op1 <= ifc.req_src1;
                        m_op2 <= ifc.req_src2;
                    end else if (ifc.req_op == 2'b01) begin
                        m_hi <= ifc.req_src1;
                    end else if (ifc.req_op == 2'b10) begin
                        m_lo <= ifc.req_src1;
                    end
                end
                1: begin
                    m_run <= m_run + 1;
                    if (ifc.cancel) begin
                        m_ph <= 2;
                    end else if (ifc.mult_end) begin
                        {m_hi, m_lo} <= mul64(m_op1, m_op2);
                        m_ph <= 2;
                    end else if (m_run + 1 == MAXC) begin
                        m_err <= 1'b1;
                        m_ph  <= 2;
                    end
                end
                default: m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            check("ready", 64'(ifc.req_ready), 64'(m_ph == 0));
            check("busy", 64'(ifc.busy), 64'(m_ph != 0));
            check("begin", 64'(ifc.mult_begin), 64'(m_ph == 1));
            check("hi", 64'(ifc.hi), 64'(m_hi));
            check("lo", 64'(ifc.lo), 64'(m_lo));
            check("err", 64'(ifc.err), 64'(m_err));
            if (m_ph == 1) begin
                check("op1", 64'(ifc.mult_op1), 64'(m_op1));
                check("op2", 64'(ifc.mult_op2), 64'(m_op2));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int waited);
        waited = 0;
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_src1  = a;
        ifc.req_src2  = b;
        while (!ifc.req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) check("issue_timeout", 64'(0), 64'(1));
        @(negedge clk);
        ifc.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ifc.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo);
        int w;
        int n = 0;
        issue(2'b00, a, b, w);
        check("run_busy", 64'(ifc.busy), 64'(1));
        while (!ifc.mult_end && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("end_timeout", 64'(0), 64'(1));
        check("old_hi_while_busy", 64'(ifc.busy), 64'(1));
        @(negedge clk);
        check("drop_begin", 64'(ifc.mult_begin), 64'(0));
        check("drop_busy", 64'(ifc.busy), 64'(1));
        check("res_hi", 64'(ifc.hi), 64'(ehi));
        check("res_lo", 64'(ifc.lo), 64'(elo));
        @(negedge clk);
        check("back_idle", 64'(ifc.busy), 64'(0));
    endtask

    initial begin
        int w;
        ifc.req_valid = 1'b0;
        ifc.req_op    = 2'b00;
        ifc.req_src1  = '0;
        ifc.req_src2  = '0;
        ifc.cancel    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(ifc.hi), 64'(0));
        check("rst_lo", 64'(ifc.lo), 64'(0));
        check("rst_begin", 64'(ifc.mult_begin), 64'(0));
        check("rst_err", 64'(ifc.err), 64'(0));
        check("rst_ready", 64'(ifc.req_ready), 64'(1));
        check("rst_op1", 64'(ifc.mult_op1), 64'(0));
        resetn = 1'b1;

        do_mult(32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
        do_mult(32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
        do_mult(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // Back-to-back moves, then a second multiply held off while busy.
        @(negedge clk);
        ifc.req_valid = 1'b1;
        ifc.req_op    = 2'b01;
        ifc.req_src1  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mthi_nobusy", 64'(ifc.busy), 64'(0));
        ifc.req_op   = 2'b10;
        ifc.req_src1 = 32'h1234_5678;
        @(negedge clk);
        check("mtlo_nobusy", 64'(ifc.busy), 64'(0));
        ifc.req_op = 2'b11;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        check("mv_hi", 64'(ifc.hi), 64'(32'hDEAD_BEEF));
        check("mv_lo", 64'(ifc.lo), 64'(32'h1234_5678));
        check("rsvd_nobusy", 64'(ifc.busy), 64'(0));
        issue(2'b00, 32'd6, 32'd7, w);
        issue(2'b00, 32'hFFFF_FFFE, 32'd9, w);
        check("holdoff", 64'(w > 0), 64'(1));
        wait_idle();
        check("mult2_hi", 64'(ifc.hi), 64'(32'hFFFF_FFFF));
        check("mult2_lo", 64'(ifc.lo), 64'(32'hFFFF_FFEE));

        // Cancel coinciding with end.
        issue(2'b01, 32'hAAAA_AAAA, 32'd0, w);
        issue(2'b10, 32'hAAAA_AAAA, 32'd0, w);
        issue(2'b00, 32'd2, 32'd2, w);
        w = 0;
        while (!ifc.mult_end && w < 200) begin
            @(negedge clk);
            w++;
        end
        ifc.cancel = 1'b1;
        @(negedge clk);
        ifc.cancel = 1'b0;
        check("cxl_drop", 64'(ifc.busy && !ifc.mult_begin), 64'(1));
        check("cxl_hi", 64'(ifc.hi), 64'(32'hAAAA_AAAA));
        check("cxl_lo", 64'(ifc.lo), 64'(32'hAAAA_AAAA));
        @(negedge clk);
        check("cxl_idle", 64'(ifc.busy), 64'(0));

        // Watchdog: multiplier never finishes.
        hang = 1'b1;
        issue(2'b00, 32'd4, 32'd4, w);
        repeat (MAXC - 3) @(negedge clk);
        check("wd_early_err", 64'(ifc.err), 64'(0));
        check("wd_early_busy", 64'(ifc.busy), 64'(1));
        wait_idle();
        check("wd_err", 64'(ifc.err), 64'(1));
        check("wd_hi", 64'(ifc.hi), 64'(32'hAAAA_AAAA));
        check("wd_lo", 64'(ifc.lo), 64'(32'hAAAA_AAAA));
        hang = 1'b0;
        do_mult(32'd1, 32'd1, 32'h0, 32'h1);
        check("err_sticky", 64'(ifc.err), 64'(1));

        // Reset in the middle of a multiply.
        hang = 1'b1;
        issue(2'b00, 32'd9, 32'd9, w);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mrst_begin", 64'(ifc.mult_begin), 64'(0));
        check("mrst_busy", 64'(ifc.busy), 64'(0));
        check("mrst_hilo", {ifc.hi, ifc.lo}, 64'(0));
        check("mrst_err", 64'(ifc.err), 64'(0));
        check("mrst_ops", {ifc.mult_op1, ifc.mult_op2}, 64'(0));
        hang = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        do_mult(32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0, 32'h0000_000F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
Control stage that sits directly around the iterative 32x32 multiplier (begin/end handshake, 64-bit product). It accepts multiply and HI/LO-move requests from the execute stage and drives the multiplier's begin and operand inputs. It captures the finished product into architectural HI/LO registers and exposes busy/stall to the pipeline. It supports flush-cancel and a cycle watchdog.

Parameters:
MAX_CYCLES, 40, watchdog limit in cycles from begin to end; exceeding it aborts the operation and flags err.
CNT_W, 6, width of watchdog counter; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block accepts request this cycle
req_op  in  2  00 MULT, 01 MTHI, 10 MTLO, 11 reserved (accepted, no effect)
req_src1  in  32  multiplicand / MTHI-MTLO data
req_src2  in  32  multiplier operand
cancel  in  1  flush: abort in-flight MULT, no HI/LO write
mult_begin  out  1  to multiplier, level held for whole operation
mult_op1  out  32  registered operand 1
mult_op2  out  32  registered operand 2
product  in  64  from multiplier, valid when mult_end=1
mult_end  in  1  from multiplier, completion pulse
hi  out  32  HI register
lo  out  32  LO register
busy  out  1  high when state != IDLE; pipeline stalls MFHI/MFLO on it
err  out  1  sticky watchdog-timeout flag, cleared only by reset

Behaviour:
- Reset (resetn=0, async): state=IDLE, hi=lo=0, mult_begin=0, mult_op1=mult_op2=0, counter=0, err=0.
- States are IDLE, RUN and DROP. req_ready = (state==IDLE).
- Accept means req_valid & req_ready.
- IDLE, MULT accepted: latch src1/src2 into mult_op1/op2, set mult_begin=1 next cycle, counter=0, go to RUN.
- IDLE, MTHI accepted: hi<=req_src1 next edge; state stays IDLE.
- IDLE, MTLO accepted: lo<=req_src1 next edge; state stays IDLE.
- IDLE, reserved op: consumed, no state change.
- RUN: mult_begin held 1 and operands held stable; counter increments each cycle.
  - mult_end=1 and cancel=0: {hi,lo}<=product on that edge; go to DROP.
  - cancel=1, with or without mult_end in the same cycle: cancel wins, no HI/LO write, go to DROP.
  - counter reaches MAX_CYCLES with no end: err<=1, no write, go to DROP.
- DROP: mult_begin=0 for exactly one cycle so the multiplier re-initialises; go to IDLE unconditionally.
  - Minimum MULT issue-to-issue spacing is therefore multiplier latency + 2 cycles.
- Multiplier operands are signed two's complement; the 64-bit product is written unmodified (hi=product[63:32], lo=product[31:0]).
- mult_end seen while not in RUN is ignored.
- cancel while not in RUN is ignored.
- HI/LO are updated only at the edge where RUN sees a valid end.
  - A read of hi/lo in the cycle after that edge sees the new value.
  - A read while busy=1 sees the old value; the pipeline must stall on busy.
- Reset asserted mid-RUN: immediate return to reset values; mult_begin drops asynchronously.

Decomposition:
- Shared package: op encodings (OP_MULT, OP_MTHI, OP_MTLO), state encodings (S_IDLE, S_RUN, S_DROP), default MAX_CYCLES.
- No sub-module needed. Bench instantiates mult_hilo_ctrl with the existing multiplier, plus a stub multiplier model for the timeout and cancel cases.

Test Plan:
- Reset release, then MULT 3 x 5 -> busy high until end, then hi=0x00000000, lo=0x0000000F; mult_begin low for exactly 1 cycle afterwards.
- MULT 0xFFFFFFFF x 0x00000001 (-1 x 1) -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- MULT 0x7FFFFFFF x 0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
- MTHI 0xDEADBEEF then MTLO 0x12345678 back-to-back -> hi=0xDEADBEEF, lo=0x12345678, busy never asserted. A following MULT issued while busy is held off (req_ready=0) until the block returns to IDLE.
- Cancel and overrun:
  - Preload hi/lo=0xAAAAAAAA; MULT 2x2, assert cancel in the same cycle as mult_end -> hi/lo unchanged at 0xAAAAAAAA, DROP then IDLE.
  - Stub multiplier never raises end -> err=1 after MAX_CYCLES, hi/lo unchanged.
  - resetn pulse mid-RUN -> all outputs 0 immediately.
